// File: rtl/ready_sched.sv
// ready_sched: round-robin wait-state scheduler for NREQ requesters sharing one slow resource.
// The owner gets ack after a per-requester programmable number of wait states.
module ready_sched #(
  parameter int NREQ     = 4,
  parameter int CW       = 4,
  parameter int DEF_WAIT = 3,
  localparam int SW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] ack_o,
  input  logic            cfg_we_i,
  input  logic [SW-1:0]   cfg_sel_i,
  input  logic [CW-1:0]   cfg_wait_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_ptr, w_ptr_nxt;
  logic [SW-1:0]   r_own, w_own_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_ack, w_ack_nxt;
  logic [CW-1:0]   r_wait [NREQ];

  logic            w_found;
  logic [SW-1:0]   w_sel;
  logic [SW-1:0]   w_own_inc;

  // First requesting index at or above r_ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    logic [SW-1:0] idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_i[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
      idx = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end
  end

  assign w_own_inc = (int'(r_own) == NREQ - 1) ? '0 : r_own + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_own_nxt   = r_own;
    w_gnt_nxt   = r_gnt;
    w_ack_nxt   = r_ack;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = WAIT;
          w_own_nxt   = w_sel;
          w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
          w_cnt_nxt   = r_wait[w_sel];
        end
      end
      WAIT, ACK: begin
        if (!req_i[r_own]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ack_nxt   = 1'b0;
          w_ptr_nxt   = w_own_inc;
        end else if (r_state == WAIT) begin
          if (r_cnt == '0) begin
            w_state_nxt = ACK;
            w_ack_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_own   <= '0;
      r_gnt   <= '0;
      r_ack   <= 1'b0;
    end else if (ce_i) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // NOTE: the wait table is a few flops that must start at DEF_WAIT, so it is reset like any other state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREQ; k++) r_wait[k] <= CW'(DEF_WAIT);
    end else if (ce_i && cfg_we_i) begin
      for (int k = 0; k < NREQ; k++) begin
        if (cfg_sel_i == SW'(k)) r_wait[k] <= cfg_wait_i;
      end
    end
  end

  // Ack drops with the owner's request in the same cycle, without waiting for an edge.
  assign ack_o  = {NREQ{r_ack}} & r_gnt & req_i;
  assign gnt_o  = r_gnt;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_ready_sched.sv
// tb_ready_sched: checks ready_sched against a grant/ack-timing model every cycle,
// plus directed scenarios with literal expectations (NREQ=4 and NREQ=3 instances).
module tb_ready_sched;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ce;
  logic [N-1:0]  req, gnt, ack;
  logic          cfg_we, busy;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_wait;

  logic [2:0]    req3, gnt3, ack3;
  logic          cfg_we3, busy3;
  logic [1:0]    cfg_sel3;
  logic [CW-1:0] cfg_wait3;

  ready_sched #(.NREQ(N), .CW(CW), .DEF_WAIT(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .req_i(req), .gnt_o(gnt), .ack_o(ack),
    .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_wait_i(cfg_wait), .busy_o(busy)
  );

  ready_sched #(.NREQ(3), .CW(CW), .DEF_WAIT(DW)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .ce_i(1'b1), .req_i(req3), .gnt_o(gnt3), .ack_o(ack3),
    .cfg_we_i(cfg_we3), .cfg_sel_i(cfg_sel3), .cfg_wait_i(cfg_wait3), .busy_o(busy3)
  );

  int n_pass, n_checks;
  bit chk_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Model: owner index (-1 idle), ack due at a count of enabled edges, table as plain ints.
  int m_owner, m_ptr, m_due, m_edge;
  bit m_ack;
  int m_tbl [N];

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_due   = 0;
    m_edge  = 0;
    m_ack   = 1'b0;
    for (int k = 0; k < N; k++) m_tbl[k] = DW;
  endfunction

  function automatic void model_step();
    m_edge++;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_due   = m_edge + m_tbl[c] + 1;
          m_ack   = 1'b0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_ack   = 1'b0;
    end else if (m_edge == m_due) begin
      m_ack = 1'b1;
    end
    if (cfg_we) m_tbl[cfg_sel] = int'(cfg_wait);
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (ce) model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_gnt", 32'(gnt), 32'(exp_gnt()));
      check("model_ack", 32'(ack), 32'(exp_gnt() & (m_ack ? req : 4'b0000)));
      check("model_busy", 32'(busy), 32'(m_owner >= 0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from the grant edge until ack_o[idx] rises on the NREQ=4 instance (bounded).
  task automatic ack_latency4(input int idx, output int lat);
    lat = 0;
    while (!ack[idx] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int rr_own [5] = '{0, 1, 2, 3, 0};

  initial begin
    n_pass = 0; n_checks = 0; chk_en = 1'b0;
    rst_n = 1'b0; ce = 1'b1; req = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wait = '0;
    req3 = '0; cfg_we3 = 1'b0; cfg_sel3 = '0; cfg_wait3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset defaults and DEF_WAIT=3 latency
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    req = 4'b0001;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    repeat (3) tick();
    check("first_ack_e4", 32'(ack), 32'h0);
    tick();
    check("first_ack_e5", 32'(ack), 32'h1);
    req = 4'b0000;
    #1 check("drop_ack_now", 32'(ack), 32'h0);
    check("drop_gnt_held", 32'(gnt), 32'h1);
    tick();
    check("drop_gnt_clr", 32'(gnt), 32'h0);

    // Zero wait on requester 2
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_wait = 4'd0;
    tick();
    cfg_we = 1'b0;
    req = 4'b0100;
    tick();
    check("w0_gnt", 32'(gnt), 32'h4);
    check("w0_ack_grant", 32'(ack), 32'h0);
    tick();
    check("w0_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    #1 check("w0_drop_ack", 32'(ack), 32'h0);
    tick();
    check("w0_gnt_clr", 32'(gnt), 32'h0);

    // Config write to the owner mid-transfer
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_wait = 4'd5;
    tick();
    cfg_we = 1'b0;
    req = 4'b0010;
    tick();
    check("cfg_gnt", 32'(gnt), 32'h2);
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_wait = 4'd1;
    tick();
    cfg_we = 1'b0;
    repeat (4) tick();
    check("cfg_ack_e5", 32'(ack), 32'h0);
    tick();
    check("cfg_ack_e6", 32'(ack), 32'h2);
    req = 4'b0000;
    repeat (2) tick();
    req = 4'b0010;
    tick();
    check("cfg2_gnt", 32'(gnt), 32'h2);
    ack_latency4(1, lat);
    check("cfg2_latency", 32'(lat), 32'd2);
    req = 4'b0000;
    repeat (2) tick();

    // Clock enable low for 4 cycles during WAIT, then drop while frozen in ACK
    req = 4'b0001;
    tick();
    check("ce_gnt", 32'(gnt), 32'h1);
    tick();
    ce = 1'b0;
    repeat (4) tick();
    ce = 1'b1;
    repeat (2) tick();
    check("ce_ack_e7", 32'(ack), 32'h0);
    tick();
    check("ce_ack_e8", 32'(ack), 32'h1);
    ce = 1'b0;
    req = 4'b0000;
    #1 check("ce_drop_ack", 32'(ack), 32'h0);
    tick();
    check("ce_frozen_gnt", 32'(gnt), 32'h1);
    ce = 1'b1;
    tick();
    check("ce_release", 32'(gnt), 32'h0);

    // Asynchronous reset in ACK, then pointer and table defaults
    req = 4'b0010;
    tick();
    check("ar_gnt", 32'(gnt), 32'h2);
    repeat (2) tick();
    check("ar_ack", 32'(ack), 32'h2);
    #1 rst_n = 1'b0;
    #1 check("ar_ack_low", 32'(ack), 32'h0);
    check("ar_gnt_low", 32'(gnt), 32'h0);
    check("ar_busy_low", 32'(busy), 32'h0);
    req = 4'b0011;
    #1 rst_n = 1'b1;
    tick();
    check("ar_ptr0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    check("ar_release", 32'(gnt), 32'h0);
    tick();
    check("ar_gnt1", 32'(gnt), 32'h2);
    ack_latency4(1, lat);
    check("ar_table_def", 32'(lat), 32'd4);
    req = 4'b0000;
    repeat (2) tick();

    // Round-robin with all requesting, starting from a fresh reset
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1) << rr_own[g]);
      ack_latency4(rr_own[g], lat);
      check("rr_latency", 32'(lat), 32'd4);
      tick();
      req[rr_own[g]] = 1'b0;
      tick();
      check("rr_dead_cycle", 32'(gnt), 32'h0);
      req[rr_own[g]] = 1'b1;
    end
    req = 4'b0000;
    repeat (2) tick();

    // NREQ=3: out-of-range config select ignored, pointer wraps 2 -> 0
    cfg_we3 = 1'b1; cfg_sel3 = 2'd3; cfg_wait3 = 4'd0;
    tick();
    cfg_we3 = 1'b0;
    req3 = 3'b100;
    tick();
    check("n3_gnt2", 32'(gnt3), 32'h4);
    lat = 0;
    while (!ack3[2] && lat < 40) begin tick(); lat++; end
    check("n3_lat2", 32'(lat), 32'd4);
    req3 = 3'b011;
    tick();
    check("n3_release", 32'(gnt3), 32'h0);
    check("n3_idle_busy", 32'(busy3), 32'h0);
    tick();
    check("n3_wrap_gnt0", 32'(gnt3), 32'h1);
    lat = 0;
    while (!ack3[0] && lat < 40) begin tick(); lat++; end
    check("n3_lat0", 32'(lat), 32'd4);
    req3 = 3'b000;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      ce       = ($urandom_range(0, 9) != 0);
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_wait = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    req = '0; ce = 1'b1; cfg_we = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
